ram_4x4_loader: RTL
===================

# ram_4x4_loader

Sequential write-side counterpart to the team's 4x4 synchronous ROM. It accepts a stream of 4-bit words over a valid/ready handshake and writes them to consecutive addresses 0..3 of an internal 4x4 register array. It also exposes a registered synchronous read port with the same addressing and one-cycle latency as the ROM, so existing readers can consume the loaded contents unchanged. It sits between a configuration source (host, UART, bench) and any logic that previously read fixed ROM contents.

## Interface
- `DATA_W`, default 4: word width.
- `DEPTH`, default 4: number of words; address width is clog2(DEPTH) = 2.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: single-cycle pulse that begins or restarts a load at address 0.
- `in_valid` input, 1 bit: `in_data` is valid this cycle.
- `in_data` input, DATA_W: word to write.
- `in_ready` output, 1 bit: loader accepts a word this cycle.
- `done` output, 1 bit: all DEPTH words have been written.
- `wr_count` output, 3 bits: number of words written in the current load (0..4).
- `address` input, 2 bits: read address.
- `data_out` output, DATA_W: registered read data.

## Operation
- **Reset:**
  - State = IDLE, with IDLE as the state encoding.
  - All memory words = 0.
  - `wr_count` = 0, `done` = 0, `in_ready` = 0, `data_out` = 0.
- **States:** IDLE, LOAD, DONE.
  - IDLE: `in_ready` = 0. A `start` pulse moves to LOAD with the write pointer set to 0.
  - LOAD: `in_ready` = ~`start`. A transfer happens when `in_valid` & `in_ready`: mem[ptr] <= `in_data`, ptr increments, `wr_count` increments. The transfer that writes address DEPTH-1 moves to DONE.
  - DONE: `done` = 1 and `in_ready` = 0. `in_valid` is ignored and memory is held. `start` moves to LOAD with ptr = 0, `wr_count` = 0 and `done` = 0.
- **`start` in LOAD:** restarts the load. ptr and `wr_count` go to 0, no word is accepted that cycle (`in_ready` is low), and previously written words stay in memory until overwritten.
- **Pointer:** 2-bit counter, 0→1→2→3. It never wraps inside one load because reaching 3 exits to DONE.
- **`wr_count` width:** 3 bits, which holds the value 4 in DONE.
- **Read port:** every rising edge, `data_out` <= mem[`address`], independent of state.
- **Read/write collision:** a read of the address being written in the same cycle returns the old word. The new word is visible on the following read edge.
- **`in_valid` without `in_ready`:** no effect. The source must hold `in_data` until a cycle where both are high.

## Timing
- **Write latency:** a word accepted at edge N is stored after edge N. A read issued at edge N+1 returns it on `data_out` after edge N+1.
- **Read latency:** 1 clock from `address` to `data_out`, matching the ROM.
- **`done` timing:** `done` rises on the edge that accepts the 4th word. `in_ready` drops on that same edge.
- **Minimum load time:** 1 clock (start) + 4 clocks, with `in_valid` held high.
- **Asynchronous reset mid-load:** returns to IDLE and clears memory immediately, without waiting for a clock edge. The first clock edge after `rst` deasserts performs no transfer.
- **`start` and `in_valid` together in IDLE:** the word is not accepted, because `in_ready` is 0 in IDLE.

## Configuration
- **Macro:** `RAM_LOADER_AUTOSTART_EN`.
- **Defined:** the reset state is LOAD (ptr = 0), so `in_ready` = 1 right after reset deasserts and no `start` pulse is needed for the first load. Later loads still need `start`.
- **Undefined:** the reset state is IDLE, and `start` is required for every load.

## Test plan
- **Reset values:** assert `rst` for 2 clocks with `in_valid` = 1. Required: `in_ready` = 0, `done` = 0, `wr_count` = 0, `data_out` = 0, and reads of addresses 0..3 return 0000.
- **Basic load and readback:** pulse `start`, then stream 1010, 0101, 1111, 0011 with `in_valid` held high. Required: `done` rises after the 4th accept and `wr_count` = 4. Reads of addresses 0..3 then return the same four words, each 1 clock after `address` is applied.
- **Backpressure gaps:** drop `in_valid` for 3 clocks between words 2 and 3. Required: `wr_count` holds at 2, no write occurs, and the final contents are correct.
- **Restart mid-load:** write 2 words (0001, 0010), pulse `start`, then write 1000, 0100, 1100, 1110. Required: memory reads back 1000, 0100, 1100, 1110, and the word presented during the `start` cycle is not accepted.
- **DONE ignores input:** after `done`, drive `in_valid` = 1 with 0000 for 5 clocks. Required: memory is unchanged and `in_ready` stays 0.
- **Read/write collision and reset mid-load:** read address 1 in the same cycle it is written with 0110. Required: the old value first, then 0110 on the next read. Then assert `rst` asynchronously mid-load. Required: all memory reads 0000 and the state is IDLE (LOAD if `RAM_LOADER_AUTOSTART_EN` is defined).

Source files
------------

// File: rtl/ram_4x4_loader.sv
// Stream loader for a DEPTH x DATA_W register array with a registered read port.
// Optional macro RAM_LOADER_AUTOSTART_EN: leave reset already in LOAD so the first load needs no start.
module ram_4x4_loader #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         in_valid,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         in_ready,
   output logic                         done,
   output logic [$clog2(DEPTH+1)-1:0]   wr_count,
   input  logic [$clog2(DEPTH)-1:0]     address,
   output logic [DATA_W-1:0]            data_out
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

`ifdef RAM_LOADER_AUTOSTART_EN
   localparam state_t RESET_STATE = S_LOAD;
`else
   localparam state_t RESET_STATE = S_IDLE;
`endif

   state_t              state;
   state_t              state_nxt;
   logic [AW-1:0]       ptr;
   logic                wr_en;
   logic                clr;
   logic [DATA_W-1:0]   mem [DEPTH];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RESET_STATE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, handshake and datapath controls; start always wins over a transfer
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      wr_en     = 1'b0;
      clr       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_LOAD;
               clr       = 1'b1;
            end
         end
         S_LOAD: begin
            in_ready = ~start;
            if (start) begin
               clr = 1'b1;
            end else if (in_valid) begin
               wr_en = 1'b1;
               if (ptr == LAST_PTR) begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (start) begin
               state_nxt = S_LOAD;
               clr       = 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Write pointer, word counter and done flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= '0;
         wr_count <= '0;
         done     <= 1'b0;
      end else begin
         done <= (state_nxt == S_DONE);
         if (clr) begin
            ptr      <= '0;
            wr_count <= '0;
         end else if (wr_en) begin
            ptr      <= ptr + AW'(1);
            wr_count <= wr_count + CNT_W'(1);
         end
      end
   end

   // Storage array; a same-edge read sees the old word through NBA ordering
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         data_out <= '0;
      end else begin
         if (wr_en) begin
            mem[ptr] <= in_data;
         end
         data_out <= mem[address];
      end
   end

endmodule
